// File: rtl/calc_mp_core.sv
// Multi-port add/sub/shift calculator: per-port two-cycle command capture into a small
// FIFO, round-robin grant of one FIFO head per cycle into a shared registered ALU.
//
// state  | meaning
// S_IDLE | waiting for a command; invalid commands are queued at once
// S_OP2  | opcode and operand 1 held; this cycle's data is operand 2
module calc_mp_core #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [NUM_PORTS-1:0]        req_busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int FP_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_OVF = 2'd2;
    localparam logic [1:0] RESP_INV = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_OP2 = 1'b1} cap_state_t;

    cap_state_t        state_q  [NUM_PORTS];
    cap_state_t        state_d  [NUM_PORTS];
    logic [3:0]        cmd_q    [NUM_PORTS];
    logic [DATA_W-1:0] op1_q    [NUM_PORTS];
    logic [NUM_PORTS-1:0] cap_en;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [3:0]        push_cmd [NUM_PORTS];
    logic [DATA_W-1:0] push_op1 [NUM_PORTS];
    logic [DATA_W-1:0] push_op2 [NUM_PORTS];

    logic [3:0]        mem_cmd  [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_op1  [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_op2  [NUM_PORTS][FIFO_DEPTH];
    logic [FP_W-1:0]   wr_ptr_q [NUM_PORTS];
    logic [FP_W-1:0]   rd_ptr_q [NUM_PORTS];
    logic [CNT_W-1:0]  count_q  [NUM_PORTS];

    logic [PTR_W-1:0]  rr_ptr_q;
    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic [3:0]        head_cmd;
    logic [DATA_W-1:0] head_op1;
    logic [DATA_W-1:0] head_op2;
    logic [DATA_W:0]   sum_ext;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    function automatic logic is_op(input logic [3:0] c);
        return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SHL) || (c == CMD_SHR);
    endfunction

    function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
        return (p == FP_W'(FIFO_DEPTH - 1)) ? '0 : p + FP_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PTR_W'(s);
    endfunction

    // One slot stays free for an operation already sitting in S_OP2.
    always_comb begin
        req_busy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_busy[i] = (count_q[i] >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_comb begin
        cap_en = '0;
        push   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]  = state_q[i];
            push_cmd[i] = '0;
            push_op1[i] = '0;
            push_op2[i] = '0;
            case (state_q[i])
                S_IDLE: begin
                    if (!req_busy[i] && (req_cmd_in[4*i +: 4] != CMD_NOP)) begin
                        if (is_op(req_cmd_in[4*i +: 4])) begin
                            cap_en[i]  = 1'b1;
                            state_d[i] = S_OP2;
                        end else begin
                            push[i]     = 1'b1;
                            push_cmd[i] = req_cmd_in[4*i +: 4];
                        end
                    end
                end
                S_OP2: begin
                    push[i]     = 1'b1;
                    push_cmd[i] = cmd_q[i];
                    push_op1[i] = op1_q[i];
                    push_op2[i] = req_data_in[DATA_W*i +: DATA_W];
                    state_d[i]  = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= S_IDLE;
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                if (cap_en[i]) begin
                    cmd_q[i] <= req_cmd_in[4*i +: 4];
                    op1_q[i] <= req_data_in[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
                mem_cmd[i][wr_ptr_q[i]] <= push_cmd[i];
                mem_op1[i][wr_ptr_q[i]] <= push_op1[i];
                mem_op2[i][wr_ptr_q[i]] <= push_op2[i];
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) wr_ptr_q[i] <= fifo_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= fifo_inc(rd_ptr_q[i]);
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_W'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Grant only looks at registered counts, so a fresh push waits one cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        pop       = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (!grant_vld && (count_q[rr_idx(rr_ptr_q, off)] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx(rr_ptr_q, off);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i] = grant_vld && (grant_idx == PTR_W'(i));
        end
    end

    always_comb begin
        head_cmd = mem_cmd[grant_idx][rd_ptr_q[grant_idx]];
        head_op1 = mem_op1[grant_idx][rd_ptr_q[grant_idx]];
        head_op2 = mem_op2[grant_idx][rd_ptr_q[grant_idx]];
        sum_ext  = {1'b0, head_op1} + {1'b0, head_op2};
        alu_resp = RESP_INV;
        alu_data = '0;
        case (head_cmd)
            CMD_ADD: begin
                alu_resp = sum_ext[DATA_W] ? RESP_OVF : RESP_OK;
                alu_data = sum_ext[DATA_W-1:0];
            end
            CMD_SUB: begin
                alu_resp = (head_op2 > head_op1) ? RESP_OVF : RESP_OK;
                alu_data = head_op1 - head_op2;
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = head_op1 << head_op2[SH_W-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = head_op1 >> head_op2[SH_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            out_resp <= '0;
            out_data <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pop[i]) begin
                    out_resp[2*i +: 2]           <= alu_resp;
                    out_data[DATA_W*i +: DATA_W] <= alu_data;
                end
            end
            if (grant_vld) rr_ptr_q <= rr_idx(grant_idx, 1);
        end
    end

endmodule

// File: tb/tb_calc_mp_core.sv
// Bench for calc_mp_core: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of capture, round-robin service and arithmetic.
module tb_calc_mp_core;

    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 4;

    logic           c_clk = 1'b0;
    logic           reset = 1'b1;
    logic [4*N-1:0] req_cmd_in;
    logic [W*N-1:0] req_data_in;
    logic [2*N-1:0] out_resp;
    logic [W*N-1:0] out_data;
    logic [N-1:0]   req_busy;

    calc_mp_core #(.NUM_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .req_busy    (req_busy)
    );

    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [3:0]   cmd;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
    } ent_t;

    ent_t         mq [N][$];
    int           mstate [N];
    logic [3:0]   mcmd [N];
    logic [W-1:0] mop1 [N];
    int           rr;
    logic [2*N-1:0] exp_resp;
    logic [W*N-1:0] exp_data;
    logic [N-1:0]   exp_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int pushes = 0;
    int seen = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            mq[p].delete();
            mstate[p] = 0;
            mcmd[p] = '0;
            mop1[p] = '0;
        end
        rr = 0;
        exp_resp = '0;
        exp_data = '0;
        exp_busy = '0;
    endtask

    function automatic void alu_ref(input ent_t e, output logic [1:0] r, output logic [W-1:0] d);
        longint unsigned a, b, s;
        a = 64'(e.op1);
        b = 64'(e.op2);
        s = 0;
        r = 2'd3;
        d = '0;
        case (e.cmd)
            4'd1: begin
                s = a + b;
                r = (s >= (64'd1 << W)) ? 2'd2 : 2'd1;
                d = s[W-1:0];
            end
            4'd2: begin
                s = a - b;
                r = (b > a) ? 2'd2 : 2'd1;
                d = s[W-1:0];
            end
            4'd5: begin
                s = a << (b % W);
                r = 2'd1;
                d = s[W-1:0];
            end
            4'd6: begin
                s = a >> (b % W);
                r = 2'd1;
                d = s[W-1:0];
            end
            default: ;
        endcase
    endfunction

    task automatic model_edge();
        logic [N-1:0] bsy;
        int g;
        ent_t e;
        logic [1:0] r;
        logic [W-1:0] d;
        logic [3:0] c;
        for (int p = 0; p < N; p++) bsy[p] = (mq[p].size() >= D - 1);
        exp_resp = '0;
        exp_data = '0;
        g = -1;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (rr + off) % N;
            if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        if (g >= 0) begin
            e = mq[g].pop_front();
            alu_ref(e, r, d);
            exp_resp[2*g +: 2] = r;
            exp_data[W*g +: W] = d;
            rr = (g + 1) % N;
        end
        for (int p = 0; p < N; p++) begin
            c = req_cmd_in[4*p +: 4];
            if (mstate[p] == 1) begin
                e.cmd = mcmd[p];
                e.op1 = mop1[p];
                e.op2 = req_data_in[W*p +: W];
                mq[p].push_back(e);
                pushes++;
                mstate[p] = 0;
            end else if (c != 4'd0 && !bsy[p]) begin
                if (c inside {4'd1, 4'd2, 4'd5, 4'd6}) begin
                    mstate[p] = 1;
                    mcmd[p] = c;
                    mop1[p] = req_data_in[W*p +: W];
                end else begin
                    e.cmd = c;
                    e.op1 = '0;
                    e.op2 = '0;
                    mq[p].push_back(e);
                    pushes++;
                end
            end
        end
        for (int p = 0; p < N; p++) exp_busy[p] = (mq[p].size() >= D - 1);
    endtask

    task automatic step();
        model_edge();
        @(posedge c_clk);
        #1;
        check_val("resp", 128'(out_resp), 128'(exp_resp));
        check_val("data", 128'(out_data), 128'(exp_data));
        check_val("busy", 128'(req_busy), 128'(exp_busy));
        for (int p = 0; p < N; p++) if (out_resp[2*p +: 2] != 2'd0) seen++;
    endtask

    task automatic drv(input int p, input logic [3:0] c, input logic [W-1:0] d);
        req_cmd_in[4*p +: 4] = c;
        req_data_in[W*p +: W] = d;
    endtask

    task automatic idle();
        req_cmd_in = '0;
        req_data_in = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int bsy_hit;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge c_clk);
        #1;
        check_val("rst_resp", 128'(out_resp), 128'd0);
        check_val("rst_data", 128'(out_data), 128'd0);
        check_val("rst_busy", 128'(req_busy), 128'd0);
        model_reset();
        reset = 1'b0;

        // all ports shift 1 left by 0x24 -> 0x10, served in port order
        for (int p = 0; p < N; p++) drv(p, 4'd5, 32'd1);
        step();
        for (int p = 0; p < N; p++) drv(p, 4'd0, 32'h24);
        step();
        idle();
        step();
        for (int k = 0; k < N; k++) begin
            check_val("shl_resp", 128'(out_resp[2*k +: 2]), 128'd1);
            check_val("shl_data", 128'(out_data[W*k +: W]), 128'h10);
            step();
        end

        drv(0, 4'd1, 32'd5);
        step();
        drv(0, 4'd0, 32'd7);
        step();
        idle();
        step();
        check_val("add_resp", 128'(out_resp[1:0]), 128'd1);
        check_val("add_data", 128'(out_data[W-1:0]), 128'd12);
        step();
        check_val("add_width", 128'(out_resp[1:0]), 128'd0);

        drv(1, 4'd1, 32'hFFFF_FFFF);
        step();
        drv(1, 4'd0, 32'd1);
        step();
        drv(1, 4'd2, 32'd3);
        step();
        check_val("add_ovf_resp", 128'(out_resp[3:2]), 128'd2);
        check_val("add_ovf_data", 128'(out_data[2*W-1:W]), 128'd0);
        drv(1, 4'd0, 32'd5);
        step();
        idle();
        step();
        check_val("sub_unf_resp", 128'(out_resp[3:2]), 128'd2);
        check_val("sub_unf_data", 128'(out_data[2*W-1:W]), 128'hFFFF_FFFE);
        repeat (3) step();

        drv(2, 4'd9, 32'hABCD);
        step();
        drv(2, 4'd1, 32'd10);
        step();
        check_val("inv_resp", 128'(out_resp[5:4]), 128'd3);
        check_val("inv_data", 128'(out_data[3*W-1:2*W]), 128'd0);
        drv(2, 4'd0, 32'd20);
        step();
        idle();
        step();
        check_val("after_inv_resp", 128'(out_resp[5:4]), 128'd1);
        check_val("after_inv_data", 128'(out_data[3*W-1:2*W]), 128'd30);
        repeat (3) step();

        // flood with invalid commands until backpressure drops some
        pushes = 0;
        seen = 0;
        bsy_hit = 0;
        for (int c = 0; c < 24; c++) begin
            for (int p = 0; p < N; p++) drv(p, 4'd9, $urandom);
            step();
            if (req_busy != '0) bsy_hit = 1;
        end
        idle();
        repeat (20) step();
        check_val("flood_count", 128'(seen), 128'(pushes));
        check_val("flood_busy", 128'(bsy_hit), 128'd1);
        check_val("flood_drop", 128'(pushes < 24 * N), 128'd1);

        // reset in the middle of an operand-2 cycle
        drv(0, 4'd9, 32'd0);
        step();
        idle();
        drv(3, 4'd1, 32'd2);
        step();
        drv(3, 4'd0, 32'd99);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_resp", 128'(out_resp), 128'd0);
        check_val("arst_data", 128'(out_data), 128'd0);
        check_val("arst_busy", 128'(req_busy), 128'd0);
        repeat (2) @(posedge c_clk);
        #1;
        idle();
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_val("post_rst_p3", 128'(out_resp[7:6]), 128'd0);
        end

        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                int sel;
                logic [3:0] cmd;
                logic [W-1:0] dat;
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2: cmd = 4'd0;
                    3:       cmd = 4'd1;
                    4:       cmd = 4'd2;
                    5:       cmd = 4'd5;
                    6:       cmd = 4'd6;
                    7:       cmd = 4'd1;
                    8:       cmd = 4'd2;
                    default: cmd = 4'($urandom_range(0, 15));
                endcase
                case ($urandom_range(0, 3))
                    0:       dat = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                    1:       dat = 32'($urandom_range(0, 40));
                    default: dat = $urandom;
                endcase
                drv(p, cmd, dat);
            end
            step();
        end
        idle();
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
